twiddle_cmul: RTL and testbench

- Pipelined complex multiplier that applies the twiddle factor W^k to one complex sample per cycle. It sits directly downstream of the real and imaginary twiddle tables.
- It receives all 16 table words of each table as flat buses and selects entry k internally.
- Its output feeds the radix-2 butterfly stage.
- Flow control is valid/ready on both sides. The twiddle tables have no handshake; their outputs are static after the first cycle out of reset.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/round_sat.sv | 27 ++
 rtl/twiddle_cmul.sv | 93 +++++++++
 tb/tb_twiddle_cmul.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and word types for the FFT datapath.
//   N        sample / twiddle word width (signed)
//   FRAC     fractional bits of the twiddle format (Q8.8, 256 = 1.0)
//   NTW      number of twiddle table entries, KW = index width
//   TAGW     sideband tag width (bin address)
//   SAT_MAX / SAT_MIN  N-bit signed saturation bounds
package fft_pkg;
  localparam int N       = 16;
  localparam int FRAC    = 8;
  localparam int NTW     = 16;
  localparam int KW      = $clog2(NTW);
  localparam int TAGW    = 5;
  localparam int PW      = 2 * N;       // product width
  localparam int SW      = 2 * N + 1;   // sum/difference width
  localparam int SAT_MAX = (2 ** (N - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (N - 1));

  typedef logic signed [N-1:0]  sample_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;
endpackage

// File: rtl/round_sat.sv
// round_sat: combinational round-half-up, arithmetic shift by FRAC and
// saturation from a 2N+1-bit signed sum down to an N-bit signed word.
//   i_sum  signed 2N+1-bit sum
//   o_q    signed N-bit rounded, saturated result
module round_sat
  import fft_pkg::*;
(
  input  sum_t    i_sum,
  output sample_t o_q
);
  // One extra bit so the rounding constant can never wrap the sum.
  localparam logic signed [SW:0] RND = (SW+1)'(2 ** (FRAC - 1));
  localparam logic signed [SW:0] HI  = (SW+1)'(SAT_MAX);
  localparam logic signed [SW:0] LO  = (SW+1)'(SAT_MIN);

  logic signed [SW:0] w_rnd;
  logic signed [SW:0] w_sh;

  assign w_rnd = $signed({i_sum[SW-1], i_sum}) + RND;
  assign w_sh  = w_rnd >>> FRAC;

  always_comb begin
    o_q = w_sh[N-1:0];
    if (w_sh > HI)      o_q = HI[N-1:0];
    else if (w_sh < LO) o_q = LO[N-1:0];
  end
endmodule

// File: rtl/twiddle_cmul.sv
// twiddle_cmul: 3-stage pipelined complex multiply of a sample by twiddle
// W^k, with k selecting one of NTW entries from flat real/imag tables.
//   clk, rst                 clock, async active-high reset
//   tw_re_flat, tw_im_flat   twiddle tables, entry k at [k*N +: N]
//   in_valid/in_ready        input handshake; in_re, in_im, in_k, in_tag
//   out_valid/out_ready      output handshake; out_re, out_im, out_tag
// All stages advance together on en = ~out_valid | out_ready.
module twiddle_cmul
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NTW*N-1:0]    tw_re_flat,
  input  logic [NTW*N-1:0]    tw_im_flat,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_re,
  input  logic signed [N-1:0] in_im,
  input  logic [KW-1:0]       in_k,
  input  logic [TAGW-1:0]     in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_re,
  output logic signed [N-1:0] out_im,
  output logic [TAGW-1:0]     out_tag
);
  logic [3:1]      r_vld;
  logic            w_en;
  sample_t         w_tw_re, w_tw_im;
  sample_t         r_a_re, r_a_im, r_w_re, r_w_im;
  prod_t           r_pr, r_pi, r_qr, r_qi;
  logic [TAGW-1:0] r_tag1, r_tag2, r_tag3;
  sample_t         r_out_re, r_out_im;
  sum_t            w_sr, w_si;
  sample_t         w_q_re, w_q_im;

  // An empty output slot never blocks; reset clears r_vld so in_ready=1.
  assign w_en      = ~r_vld[3] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[3];
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_tag   = r_tag3;

  assign w_tw_re = tw_re_flat[in_k*N +: N];
  assign w_tw_im = tw_im_flat[in_k*N +: N];

  assign w_sr = sum_t'(r_pr) - sum_t'(r_pi);
  assign w_si = sum_t'(r_qr) + sum_t'(r_qi);

  round_sat u_rs_re (.i_sum(w_sr), .o_q(w_q_re));
  round_sat u_rs_im (.i_sum(w_si), .o_q(w_q_im));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= '0;
      r_a_re   <= '0;
      r_a_im   <= '0;
      r_w_re   <= '0;
      r_w_im   <= '0;
      r_tag1   <= '0;
      r_pr     <= '0;
      r_pi     <= '0;
      r_qr     <= '0;
      r_qi     <= '0;
      r_tag2   <= '0;
      r_out_re <= '0;
      r_out_im <= '0;
      r_tag3   <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[2:1], in_valid};
      if (in_valid) begin
        r_a_re <= in_re;
        r_a_im <= in_im;
        r_w_re <= w_tw_re;
        r_w_im <= w_tw_im;
        r_tag1 <= in_tag;
      end
      if (r_vld[1]) begin
        r_pr   <= r_a_re * r_w_re;
        r_pi   <= r_a_im * r_w_im;
        r_qr   <= r_a_re * r_w_im;
        r_qi   <= r_a_im * r_w_re;
        r_tag2 <= r_tag1;
      end
      if (r_vld[2]) begin
        r_out_re <= w_q_re;
        r_out_im <= w_q_im;
        r_tag3   <= r_tag2;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_cmul.sv
module tb_twiddle_cmul;
  import fft_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NTW*N-1:0]    tw_re_flat, tw_im_flat;
  logic                in_valid, in_ready, out_valid, out_ready;
  logic signed [N-1:0] in_re, in_im, out_re, out_im;
  logic [KW-1:0]       in_k;
  logic [TAGW-1:0]     in_tag, out_tag;

  always #5 clk = ~clk;

  twiddle_cmul dut (
    .clk(clk), .rst(rst), .tw_re_flat(tw_re_flat), .tw_im_flat(tw_im_flat),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .in_k(in_k), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_tag(out_tag)
  );

  typedef struct {
    logic signed [N-1:0] re, im;
    logic [KW-1:0]       k;
    logic [TAGW-1:0]     tag;
    logic signed [N-1:0] ere, eim;
  } vec_t;

  vec_t    tv[11];
  vec_t    cur;
  vec_t    e_m;
  vec_t    exp_q[$];
  int      errors = 0;
  int      checks = 0;
  int      n_out  = 0;
  int      n_stall = 0;
  logic    prev_stall = 1'b0;
  sample_t p_re, p_im;
  logic [TAGW-1:0] p_tag;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input int k, input int re, input int im,
                      input int ere, input int eim);
    tv[i].k   = KW'(k);
    tv[i].re  = sample_t'(re);
    tv[i].im  = sample_t'(im);
    tv[i].tag = TAGW'(i + 3);
    tv[i].ere = sample_t'(ere);
    tv[i].eim = sample_t'(eim);
  endtask

  task automatic set_tw(input int k, input int re, input int im);
    tw_re_flat[k*N +: N] = sample_t'(re);
    tw_im_flat[k*N +: N] = sample_t'(im);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic drive(input vec_t v);
    int n;
    cur      = v;
    in_re    = v.re;
    in_im    = v.im;
    in_k     = v.k;
    in_tag   = v.tag;
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL drive_timeout: in_ready stuck at 0 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // Scoreboard and stall monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_re", out_re, p_re);
        chk("hold_im", out_im, p_im);
        chk("hold_tag", out_tag, p_tag);
      end
      if (out_valid && !out_ready) begin
        n_stall++;
        chk("stall_in_ready", int'(in_ready), 0);
      end
      if (in_valid && in_ready) exp_q.push_back(cur);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_out: re=%0d im=%0d tag=%0d with none pending",
                   out_re, out_im, out_tag);
        end else begin
          e_m = exp_q.pop_front();
          chk($sformatf("out_re tag%0d", e_m.tag), out_re, e_m.ere);
          chk($sformatf("out_im tag%0d", e_m.tag), out_im, e_m.eim);
          chk("out_tag", out_tag, e_m.tag);
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      p_re  = out_re;
      p_im  = out_im;
      p_tag = out_tag;
    end
  end

  initial begin
    int lat, n0;
    tw_re_flat = '0;
    tw_im_flat = '0;
    set_tw(0, 256, 0);
    set_tw(1, 251, -50);
    set_tw(2, 181, 181);
    set_tw(3, 128, 0);
    set_tw(8, 0, -256);
    set_tw(15, -256, 0);
    //   idx k   in_re   in_im   exp_re  exp_im
    setv(0,  0,  100,    -50,    100,    -50);
    setv(1,  8,  100,    -50,    -50,    -100);
    setv(2,  8,  -32768, -32768, -32768, 32767);
    setv(3,  1,  1,      0,      1,      0);
    setv(4,  1,  128,    128,    151,    101);
    setv(5,  2,  256,    0,      181,    181);
    setv(6,  2,  -100,   200,    -212,   71);
    setv(7,  3,  3,      0,      2,      0);
    setv(8,  3,  -3,     0,      -1,     0);
    setv(9,  15, -32768, 0,      32767,  0);
    setv(10, 0,  32767,  -32768, 32767,  -32768);
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_k      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Table vectors, back to back
    for (int i = 0; i < 11; i++) drive(tv[i]);
    in_valid = 1'b0;
    drain("table_drain");

    // Latency of a lone sample
    @(posedge clk); #1;
    drive(tv[4]);
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    drain("latency_drain");

    // Backpressure: out_ready low for six cycles mid-stream
    @(posedge clk); #1;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) drive(tv[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - n0, 6);
    chk("bp_stalled", int'(n_stall > 0), 1);

    // Reset with three samples in flight
    @(posedge clk); #1;
    drive(tv[0]);
    drive(tv[1]);
    drive(tv[2]);
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_re", out_re, 0);
    chk("mid_rst_im", out_im, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n0 = n_out;
    drive(tv[3]);
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("post_rst_latency", lat, 3);
    drain("post_rst_drain");
    chk("post_rst_count", n_out - n0, 1);

    repeat (5) @(negedge clk);
    chk("final_no_output", int'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
